// File: rtl/chimp_pkg.sv
// chimp_pkg: shared state encoding and default game parameters for the chimp memory game controller.
package chimp_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHOW, PLAY, CHECK, NEXT, OVER} state_t;
   localparam int         DEF_START_LEVEL = 4;
   localparam int         DEF_MAX_LEVEL   = 25;
   localparam int         DEF_MAX_STRIKES = 3;
   localparam logic [7:0] DEF_LFSR_SEED   = 8'hA5;
endpackage

// File: rtl/chimp_lfsr8.sv
// chimp_lfsr8: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, maximal length so a nonzero seed never reaches zero.
module chimp_lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] o_rand
);
   logic [7:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;

   assign o_rand = lfsr_q;
endmodule

// File: rtl/chimp_take2_control.sv
// chimp_take2_control: game FSM, level/strike/score counters and click edge detection for the chimp memory game.
module chimp_take2_control
   import chimp_pkg::*;
#(
   parameter int         START_LEVEL = DEF_START_LEVEL,
   parameter int         MAX_LEVEL   = DEF_MAX_LEVEL,
   parameter int         MAX_STRIKES = DEF_MAX_STRIKES,
   parameter logic [7:0] LFSR_SEED   = DEF_LFSR_SEED
) (
   input  logic       clk,
   input  logic       iResetn,
   input  logic       iStart,
   input  logic       iMouseClick,
   input  logic       iDoneLoad,
   input  logic       iChoseCorrectNum,
   input  logic       iChoseWrongNum,
   output logic       oResetBoard,
   output logic       oLoadEnable,
   output logic       oShowEnable,
   output logic       oMouseClick,
   output logic [4:0] oLevel,
   output logic [4:0] oNumToChoose,
   output logic [7:0] oRandNum,
   output logic [1:0] oStrikes,
   output logic [5:0] oScore,
   output logic       oGameOver,
   output logic       oWin
);
   // Reset asserts immediately but releases two clk edges after iResetn rises.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge iResetn)
      if (!iResetn) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};

   assign rst_n = rst_sync_q[1];

   state_t     state_q, state_d;
   logic [4:0] level_q, level_d, num_q, num_d;
   logic [1:0] strikes_q, strikes_d, wait_q, wait_d;
   logic [5:0] score_q, score_d;
   logic       win_q, win_d, click_q, click_prev_q, mouse_q, mouse_d, click_edge;

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      num_d      = num_q;
      strikes_d  = strikes_q;
      score_d    = score_q;
      win_d      = win_q;
      wait_d     = '0;
      click_edge = click_q & ~click_prev_q;
      mouse_d    = click_edge && (state_q == SHOW || state_q == PLAY);
      case (state_q)
         IDLE:       if (iStart) state_d = CLEAR;
         CLEAR:      state_d = LOAD;
         LOAD:       if (iDoneLoad) state_d = SHOW;
         SHOW, PLAY: if (click_edge) state_d = CHECK;
         CHECK: begin
            wait_d = wait_q + 2'd1;
            // Wrong wins a tie; silence on the fourth CHECK cycle is a wrong answer.
            if (iChoseWrongNum || (!iChoseCorrectNum && wait_q == 2'd3)) begin
               strikes_d = strikes_q + 2'd1;
               state_d   = (strikes_d == 2'(MAX_STRIKES)) ? OVER : CLEAR;
            end else if (iChoseCorrectNum) begin
               num_d   = (num_q < level_q) ? num_q + 5'd1 : num_q;
               state_d = (num_q < level_q) ? PLAY : NEXT;
            end
         end
         NEXT: begin
            score_d = {1'b0, level_q};
            win_d   = (level_q == 5'(MAX_LEVEL));
            level_d = (level_q == 5'(MAX_LEVEL)) ? level_q : level_q + 5'd1;
            state_d = (level_q == 5'(MAX_LEVEL)) ? OVER : CLEAR;
         end
         OVER: if (iStart) begin
            state_d   = CLEAR;
            level_d   = 5'(START_LEVEL);
            strikes_d = '0;
            score_d   = '0;
            win_d     = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == CLEAR) num_d = 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         level_q      <= 5'(START_LEVEL);
         num_q        <= 5'd1;
         strikes_q    <= '0;
         score_q      <= '0;
         win_q        <= 1'b0;
         wait_q       <= '0;
         click_q      <= 1'b0;
         click_prev_q <= 1'b0;
         mouse_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         num_q        <= num_d;
         strikes_q    <= strikes_d;
         score_q      <= score_d;
         win_q        <= win_d;
         wait_q       <= wait_d;
         click_q      <= iMouseClick;
         click_prev_q <= click_q;
         mouse_q      <= mouse_d;
      end

   chimp_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .o_rand(oRandNum)
   );

   assign oResetBoard  = (state_q == CLEAR);
   assign oLoadEnable  = (state_q == LOAD);
   assign oShowEnable  = (state_q == LOAD) || (state_q == SHOW);
   assign oMouseClick  = mouse_q;
   assign oLevel       = level_q;
   assign oNumToChoose = num_q;
   assign oStrikes     = strikes_q;
   assign oScore       = score_q;
   assign oGameOver    = (state_q == OVER);
   assign oWin         = win_q;
endmodule

// File: tb/tb_chimp_take2_control.sv
// tb_chimp_take2_control: directed bench for the chimp game controller with hand-computed expectations.
module tb_chimp_take2_control;
   logic       clk = 1'b0;
   logic       iResetn = 1'b0, iStart = 1'b0, iMouseClick = 1'b0, iDoneLoad = 1'b0;
   logic       iChoseCorrectNum = 1'b0, iChoseWrongNum = 1'b0;
   logic       oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver, oWin;
   logic [4:0] oLevel, oNumToChoose;
   logic [7:0] oRandNum;
   logic [1:0] oStrikes;
   logic [5:0] oScore;
   int         checks = 0, errors = 0;

   chimp_take2_control dut (
      .clk(clk), .iResetn(iResetn), .iStart(iStart), .iMouseClick(iMouseClick),
      .iDoneLoad(iDoneLoad), .iChoseCorrectNum(iChoseCorrectNum), .iChoseWrongNum(iChoseWrongNum),
      .oResetBoard(oResetBoard), .oLoadEnable(oLoadEnable), .oShowEnable(oShowEnable),
      .oMouseClick(oMouseClick), .oLevel(oLevel), .oNumToChoose(oNumToChoose), .oRandNum(oRandNum),
      .oStrikes(oStrikes), .oScore(oScore), .oGameOver(oGameOver), .oWin(oWin)
   );

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_round;
      cyc;
      iDoneLoad = 1'b1;
      cyc;
      iDoneLoad = 1'b0;
   endtask

   task automatic click_verdict(input logic c, input logic w);
      iMouseClick = 1'b1;
      cyc;
      cyc;
      chk("click_pulse", oMouseClick, 1);
      iMouseClick = 1'b0;
      iChoseCorrectNum = c;
      iChoseWrongNum = w;
      cyc;
      iChoseCorrectNum = 1'b0;
      iChoseWrongNum = 1'b0;
   endtask

   initial begin
      int  pulses, dups, zeros, rb_hits;
      logic [7:0] first_v;
      logic seen [256];
      repeat (3) cyc;
      chk("rst_level", oLevel, 4);
      chk("rst_num", oNumToChoose, 1);
      chk("rst_strikes", oStrikes, 0);
      chk("rst_score", oScore, 0);
      chk("rst_rand", oRandNum, 8'hA5);
      chk("rst_outs", {oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver, oWin}, 0);
      // Start held from release: nothing may happen before the third edge.
      iResetn = 1'b1;
      iStart = 1'b1;
      cyc;
      chk("sync_e1_rb", oResetBoard, 0);
      chk("sync_e1_rand", oRandNum, 8'hA5);
      cyc;
      chk("sync_e2_rb", oResetBoard, 0);
      chk("sync_e2_rand", oRandNum, 8'hA5);
      cyc;
      chk("start_clear", oResetBoard, 1);
      chk("lfsr_1", oRandNum, 8'h4A);
      iStart = 1'b0;
      cyc;
      chk("lfsr_2", oRandNum, 8'h95);
      chk("clear_1cyc", oResetBoard, 0);
      chk("load_en", {oLoadEnable, oShowEnable}, 2'b11);
      chk("start_level", oLevel, 4);
      cyc;
      chk("load_hold", {oLoadEnable, oShowEnable}, 2'b11);
      iDoneLoad = 1'b1;
      cyc;
      iDoneLoad = 1'b0;
      chk("show_state", {oLoadEnable, oShowEnable}, 2'b01);
      // Wrong rounds: explicit, timeout, then both verdicts together.
      click_verdict(1'b0, 1'b1);
      chk("wrong1_strikes", oStrikes, 1);
      chk("wrong1_clear", oResetBoard, 1);
      chk("wrong1_level", oLevel, 4);
      load_round;
      pulses = 0;
      iMouseClick = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc;
         pulses += int'(oMouseClick);
         if (i == 4) chk("to_still_check", {oResetBoard, oStrikes}, 3'b001);
         if (i == 5) chk("to_wrong", {oResetBoard, oStrikes}, 3'b110);
      end
      iMouseClick = 1'b0;
      chk("held_one_pulse", pulses, 1);
      chk("to_level", oLevel, 4);
      iDoneLoad = 1'b1;
      cyc;
      iDoneLoad = 1'b0;
      click_verdict(1'b1, 1'b1);
      chk("both_strikes", oStrikes, 3);
      chk("over", oGameOver, 1);
      chk("over_level", oLevel, 4);
      chk("over_enables", {oResetBoard, oLoadEnable, oShowEnable}, 0);
      cyc;
      chk("over_stays", oGameOver, 1);
      iStart = 1'b1;
      cyc;
      chk("restart_clear", {oResetBoard, oGameOver}, 2'b10);
      chk("restart_strikes", oStrikes, 0);
      chk("restart_level", oLevel, 4);
      cyc;
      chk("restart_once_a", {oResetBoard, oLoadEnable}, 2'b01);
      iStart = 1'b0;
      cyc;
      chk("restart_once_b", {oResetBoard, oLoadEnable}, 2'b01);
      iDoneLoad = 1'b1;
      cyc;
      iDoneLoad = 1'b0;
      // Level 4 cleared by four correct clicks.
      for (int k = 1; k <= 4; k++) begin
         click_verdict(1'b1, 1'b0);
         if (k == 1) chk("hide_after_first", {oShowEnable, oNumToChoose}, {1'b0, 5'd2});
      end
      chk("next_no_clear", oResetBoard, 0);
      cyc;
      chk("next_score", oScore, 4);
      chk("next_level", oLevel, 5);
      chk("next_clear", {oResetBoard, oNumToChoose}, {1'b1, 5'd1});
      load_round;
      click_verdict(1'b1, 1'b0);
      chk("play_num", oNumToChoose, 2);
      // Asynchronous reset mid-round.
      #2 iResetn = 1'b0;
      #1;
      chk("arst_level", oLevel, 4);
      chk("arst_num", oNumToChoose, 1);
      chk("arst_rand", oRandNum, 8'hA5);
      chk("arst_score", oScore, 0);
      chk("arst_outs", {oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver, oWin}, 0);
      cyc;
      iResetn = 1'b1;
      cyc;
      cyc;
      chk("arst_hold_rand", oRandNum, 8'hA5);
      dups = 0;
      zeros = 0;
      rb_hits = 0;
      for (int v = 0; v < 256; v++) seen[v] = 1'b0;
      cyc;
      first_v = oRandNum;
      for (int n = 0; n < 255; n++) begin
         if (oRandNum == 8'h00) zeros++;
         if (seen[oRandNum]) dups++;
         seen[oRandNum] = 1'b1;
         rb_hits += int'(oResetBoard);
         cyc;
      end
      chk("lfsr_first_after_rst", first_v, 8'h4A);
      chk("lfsr_dups", dups, 0);
      chk("lfsr_zeros", zeros, 0);
      chk("lfsr_period", oRandNum, 8'h4A);
      chk("idle_no_clear", rb_hits, 0);
      // Full game to the win.
      iStart = 1'b1;
      cyc;
      iStart = 1'b0;
      for (int l = 4; l <= 25; l++) begin
         load_round;
         for (int k = 1; k <= l; k++) click_verdict(1'b1, 1'b0);
         cyc;
         if (l < 25) chk("win_run_level", oLevel, l + 1);
      end
      chk("win_score", oScore, 25);
      chk("win_flags", {oWin, oGameOver}, 2'b11);
      chk("win_level_cap", oLevel, 25);
      cyc;
      chk("win_hold", {oWin, oGameOver, oLevel}, {2'b11, 5'd25});
      iStart = 1'b1;
      cyc;
      iStart = 1'b0;
      chk("win_restart", {oWin, oGameOver, oScore, oLevel}, {2'b00, 6'd0, 5'd4});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
